// File: rtl/rng_lfsr63.sv
// Free-running Fibonacci LFSR random source with a range-fitted output
// (lo + rnd mod span). The seed is reloadable and a zero seed is replaced by 1.
module rng_lfsr63 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             reload,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] span,
    output logic [WIDTH-1:0] rnd,
    output logic [WIDTH-1:0] rnd_fit,
    output logic             wrap
);

    if (WIDTH < 3 || WIDTH > 12) begin : g_bad_width
        $error("rng_lfsr63: WIDTH must be in 3..12");
    end

    // Maximal-length tap sets; bit k-1 set for tap position k.
    function automatic logic [11:0] tap_mask(input int w);
        case (w)
            3:       return 12'h006;
            4:       return 12'h00C;
            5:       return 12'h014;
            6:       return 12'h030;
            7:       return 12'h060;
            8:       return 12'h0B8;
            9:       return 12'h110;
            10:      return 12'h240;
            11:      return 12'h500;
            12:      return 12'hE08;
            default: return 12'h000;
        endcase
    endfunction

    localparam logic [11:0]      TAP_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAP_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             wrap_q,  wrap_d;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] lfsr_next;
    logic             fb;

    // All-zero is the lockup state, so a zero seed is never loaded as-is.
    assign seed_eff  = (seed == '0) ? WIDTH'(1) : seed;
    assign fb        = ^(state_q & TAPS);
    assign lfsr_next = {state_q[WIDTH-2:0], fb};

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        wrap_d  = 1'b0;
        if (reload) begin
            state_d = seed_eff;
            start_d = seed_eff;
        end else if (en) begin
            state_d = lfsr_next;
            wrap_d  = (lfsr_next == start_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= seed_eff;
            start_q <= seed_eff;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            wrap_q  <= wrap_d;
        end
    end

    logic [WIDTH-1:0] span_safe;
    logic [WIDTH-1:0] rnd_mod;

    assign span_safe = (span == '0) ? WIDTH'(1) : span;
    assign rnd_mod   = (span == '0) ? '0 : (state_q % span_safe);
    assign rnd_fit   = lo + rnd_mod;
    assign rnd       = state_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_rng_lfsr63.sv
// Bench for rng_lfsr63: directed vector table, hand-written corner sequences,
// and randomized traffic against a tap-list reference model.
module tb_rng_lfsr63;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] seed = '0;
    logic         en = 1'b0;
    logic         reload = 1'b0;
    logic [W-1:0] lo = '0;
    logic [W-1:0] span = '0;
    logic [W-1:0] rnd;
    logic [W-1:0] rnd_fit;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    rng_lfsr63 #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .seed(seed), .en(en), .reload(reload),
        .lo(lo), .span(span), .rnd(rnd), .rnd_fit(rnd_fit), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: taps as 1-based positions, arithmetic on ints.
    int taps[2] = '{6, 5};
    int m_state, m_start, m_wrap;

    function automatic int sub0(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int ref_next(input int s);
        int fb = 0;
        foreach (taps[k]) fb ^= (s >> (taps[k] - 1)) & 1;
        return ((s * 2) + fb) % (1 << W);
    endfunction

    function automatic int ref_fit(input int r, input int l, input int sp);
        if (sp == 0) return l;
        return (l + (r % sp)) % (1 << W);
    endfunction

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit rst;
        int seed;
        int lo;
        int span;
        int exp_rnd;
        int exp_fit;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int r0, distinct, wraps, last_wrap;
        bit seen[64];

        vecs[0] = '{1'b1, 38,  5,  0, 38,  5};
        vecs[1] = '{1'b0, 38, 63,  2, 13,  0};
        vecs[2] = '{1'b0, 38,  0, 10, 26,  6};
        vecs[3] = '{1'b0, 38,  1, 37, 53, 17};
        vecs[4] = '{1'b0, 38,  3, 63, 42, 45};
        vecs[5] = '{1'b1, 41,  1,  1, 41,  1};
        vecs[6] = '{1'b0, 41,  2,  7, 19,  7};
        vecs[7] = '{1'b0, 41, 10, 63, 39, 49};

        // Directed table: reset-loaded seeds, advance and range fit.
        en = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            lo   = W'(vecs[i].lo);
            span = W'(vecs[i].span);
            if (vecs[i].rst) begin
                seed = W'(vecs[i].seed);
                pulse_reset();
            end
            #1;
            chk($sformatf("vec%0d_rnd", i), int'(rnd), vecs[i].exp_rnd);
            chk($sformatf("vec%0d_fit", i), int'(rnd_fit), vecs[i].exp_fit);
            chk($sformatf("vec%0d_wrap", i), int'(wrap), 0);
        end

        // Enable gating: state frozen, no wrap.
        @(negedge clk);
        en = 1'b0;
        r0 = int'(rnd);
        repeat (5) begin
            @(negedge clk);
            chk("hold_rnd", int'(rnd), r0);
            chk("hold_wrap", int'(wrap), 0);
        end

        // Zero seed is substituted by 1.
        seed = '0;
        en   = 1'b1;
        pulse_reset();
        #1;
        chk("zseed_rnd0", int'(rnd), 1);
        foreach (taps[k]) ;
        begin
            int zexp[5] = '{2, 4, 8, 16, 33};
            foreach (zexp[j]) begin
                @(negedge clk);
                chk($sformatf("zseed_rnd%0d", j + 1), int'(rnd), zexp[j]);
            end
        end

        // Full period from seed 1.
        @(negedge clk);
        seed = W'(1);
        pulse_reset();
        #1;
        chk("period_start", int'(rnd), 1);
        foreach (seen[v]) seen[v] = 1'b0;
        distinct = 0;
        wraps = 0;
        last_wrap = 0;
        for (int i = 1; i <= 63; i++) begin
            @(negedge clk);
            if (rnd == '0) chk("period_nonzero", int'(rnd), 1);
            if (!seen[rnd]) distinct++;
            seen[rnd] = 1'b1;
            wraps += int'(wrap);
            last_wrap = int'(wrap);
        end
        chk("period_distinct", distinct, 63);
        chk("period_wraps", wraps, 1);
        chk("period_end_rnd", int'(rnd), 1);
        chk("period_end_wrap", last_wrap, 1);

        // Reload wins over en; seed changes ignored until reload.
        seed = W'(38);
        pulse_reset();
        repeat (3) @(negedge clk);
        chk("reload_pre", int'(rnd), 53);
        seed = W'(7);
        @(negedge clk);
        chk("seed_ignored", int'(rnd), 42);
        seed = W'(38);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_rnd", int'(rnd), 38);
        chk("reload_wrap", int'(wrap), 0);
        repeat (2) @(negedge clk);
        chk("reload_adv", int'(rnd), 26);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst", int'(rnd), 38);
        reset_n = 1'b1;

        // Randomized traffic against the reference model.
        @(negedge clk);
        seed = W'(38);
        pulse_reset();
        m_state = 38;
        m_start = 38;
        m_wrap  = 0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            chk("rand_rnd", int'(rnd), m_state);
            chk("rand_fit", int'(rnd_fit), ref_fit(m_state, int'(lo), int'(span)));
            chk("rand_wrap", int'(wrap), m_wrap);
            seed   = ($urandom % 8 == 0) ? '0 : W'($urandom_range(0, 63));
            en     = ($urandom % 4) != 0;
            reload = ($urandom % 16) == 0;
            lo     = W'($urandom_range(0, 63));
            span   = ($urandom % 8 == 0) ? '0 : W'($urandom_range(0, 63));
            if ($urandom % 50 == 0) begin
                pulse_reset();
                m_state = sub0(int'(seed));
                m_start = m_state;
                m_wrap  = 0;
            end
            if (reload) begin
                m_state = sub0(int'(seed));
                m_start = m_state;
                m_wrap  = 0;
            end else if (en) begin
                m_state = ref_next(m_state);
                m_wrap  = (m_state == m_start) ? 1 : 0;
            end else begin
                m_wrap = 0;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
